fetch_pf: RTL and testbench
===========================

FETCH_PF -- requirements
Module: fetch_pf

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h80020000, PC value after reset.
REQ-002 SHALL have parameter WORD_SIZE, default 4, bytes per fetch and PC increment.
REQ-003 SHALL have parameter QDEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-004 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: enable_fetch  in  1  permit new memory requests; stall  in  1  downstream not consuming.
REQ-006 SHALL have ports: redirect  in  1  branch/jump taken; redirect_pc  in  32  new fetch target.
REQ-007 SHALL have ports: mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  32  request address.
REQ-008 SHALL have ports: rw  out  1  constant 1 (read); access_size  out  32  constant WORD_SIZE.
REQ-009 SHALL have ports: mem_rsp_valid  in  1; mem_rsp_data  in  32  in-order read data.
REQ-010 SHALL have ports: inst_valid  out  1; inst_pc  out  32; inst_data  out  32  queue head.

Function
REQ-011 SHALL treat a request as accepted when mem_req_valid && mem_req_ready; mem_addr then advances by WORD_SIZE, wrapping modulo 2^32.
REQ-012 SHALL keep mem_req_valid and mem_addr stable while mem_req_valid && !mem_req_ready, unless redirect or reset.
REQ-013 SHALL track outstanding (accepted, unanswered) requests; mem_req_valid = state RUN && enable_fetch && !redirect && (occupancy + outstanding < QDEPTH).
REQ-014 SHALL implement states RUN and FLUSH; reset enters RUN.
REQ-015 In RUN, mem_rsp_valid without redirect SHALL push mem_rsp_data into the queue; inst_valid rises the following cycle (1-cycle latency).
REQ-016 SHALL pop the queue head when inst_valid && !stall; inst_pc then advances by WORD_SIZE; simultaneous push and pop keeps occupancy unchanged.
REQ-017 On redirect (any state) SHALL, at that edge: empty the queue, set mem_addr and inst_pc to {redirect_pc[31:2],2'b00}, load drop count = outstanding minus any response in that cycle.
REQ-018 After redirect SHALL enter FLUSH if drop count > 0, else remain in RUN.
REQ-019 In FLUSH SHALL discard each response, decrement drop count, issue no requests; returns to RUN at the edge where drop count reaches 0.
REQ-020 A response coinciding with redirect SHALL be discarded, never queued.
REQ-021 With enable_fetch low SHALL issue nothing but still accept responses and drain the queue.
REQ-022 Queue SHALL never overflow (guaranteed by REQ-013); pop on empty SHALL not occur.

Reset
REQ-023 On reset SHALL set mem_addr = inst_pc = START_ADDR, mem_req_valid = 0, inst_valid = 0, outstanding = 0, drop count = 0, queue empty, state RUN; rw = 1, access_size = WORD_SIZE.
REQ-024 Reset mid-operation SHALL abandon all outstanding requests; memory is reset by the same reset and returns no responses for pre-reset requests.

Configuration
REQ-025 With FETCH_PF_PERF_EN defined SHALL add outputs perf_fetch_cnt (32, increments per accepted request) and perf_redirect_cnt (32, increments per redirect cycle), both cleared by reset and wrapping.
REQ-026 Without FETCH_PF_PERF_EN SHALL omit those ports and counters; all other behaviour identical.

Verification
REQ-027 Reset, enable_fetch=1, mem_req_ready=1, 1-cycle memory -> mem_addr 80020000, 80020004, 80020008...; inst_pc/inst_data in order, one per cycle once streaming.
REQ-028 stall=1 held, QDEPTH=4 -> exactly 4 requests accepted, mem_req_valid then 0; releasing stall resumes issue after first pop.
REQ-029 mem_req_ready=0 for 3 cycles -> mem_req_valid=1, mem_addr 80020000 held constant throughout.
REQ-030 Redirect to 80030002 with 2 outstanding -> queue empty next cycle, FLUSH drops 2 responses, next request address 80030000, first inst_pc 80030000.
REQ-031 Redirect in same cycle as response and last outstanding -> response dropped, state stays RUN, no request issued that cycle.
REQ-032 mem_addr FFFFFFFC accepted -> next mem_addr 00000000; with FETCH_PF_PERF_EN, perf_fetch_cnt matches accepted-request count.

Source files
------------

// File: rtl/fetch_pf.sv
// -----------------------------------------------------------------------------
// fetch_pf : instruction fetch unit with an in-order prefetch queue.
//
// Issues sequential word reads to instruction memory. It keeps the number of
// queued plus in-flight words within the queue capacity, so the queue can never
// overflow. Returned words are buffered in a small FIFO that feeds the decode
// stage.
//
// A redirect empties the queue and retargets both the fetch address and the
// head PC. Responses that are still in flight for the old path are then
// discarded while the unit is in the FLUSH state.
//
// Parameters
//   START_ADDR : PC / fetch address after reset
//   WORD_SIZE  : bytes per fetch and PC increment
//   QDEPTH     : queue entries (power of two, 2..16)
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   enable_fetch          : permits new memory requests
//   stall                 : downstream is not consuming the queue head
//   redirect, redirect_pc : taken branch/jump and its target
//   mem_req_valid/ready   : request handshake; mem_addr is the request address
//   rw, access_size       : constant read / WORD_SIZE request attributes
//   mem_rsp_valid/data    : in-order read responses
//   inst_valid/pc/data    : queue head presented to decode
//
// Optional build macro FETCH_PF_PERF_EN adds two output counters:
//   perf_fetch_cnt    : accepted requests
//   perf_redirect_cnt : redirect cycles
// -----------------------------------------------------------------------------
module fetch_pf #(
   parameter logic [31:0] START_ADDR = 32'h80020000,
   parameter int          WORD_SIZE  = 4,
   parameter int          QDEPTH     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_fetch,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        rw,
   output logic [31:0] access_size,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_data
`ifdef FETCH_PF_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0]   QDEPTH_W = QDEPTH[CW:0];
   localparam logic [CW-1:0] ONE_C    = 1;
   localparam logic [PW-1:0] ONE_P    = 1;
   localparam logic [31:0]   WSTEP    = WORD_SIZE[31:0];

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t state_reg, state_next;

   logic [31:0]   mem_addr_reg;
   logic [31:0]   inst_pc_reg;
   logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic [CW-1:0] outst_reg, outst_next;
   logic [CW-1:0] drop_reg, drop_next;
   logic [31:0]   queue_mem [QDEPTH];

   logic          accept, push, pop, rsp_dec;
   logic [CW:0]   occ_sum;
   logic [31:0]   target_pc;
   logic [1:0]    unused_pc_bits;

   // Targets are always word aligned; the low bits of redirect_pc are ignored.
   assign target_pc      = {redirect_pc[31:2], 2'b00};
   assign unused_pc_bits = redirect_pc[1:0];

   assign rw          = 1'b1;
   assign access_size = WSTEP;
   assign mem_addr    = mem_addr_reg;
   assign inst_pc     = inst_pc_reg;
   assign inst_valid  = (count_reg != '0);
   assign inst_data   = queue_mem[rd_ptr_reg];

   always_comb begin
      occ_sum = {1'b0, count_reg} + {1'b0, outst_reg};
      // Queued plus in-flight words must stay within capacity. While a request
      // waits for ready this sum can only shrink, so a pending request never
      // drops by itself.
      mem_req_valid = !reset && (state_reg == ST_RUN) && enable_fetch &&
                      !redirect && (occ_sum < QDEPTH_W);
      accept  = mem_req_valid && mem_req_ready;
      push    = (state_reg == ST_RUN) && mem_rsp_valid && !redirect;
      pop     = inst_valid && !stall;
      rsp_dec = mem_rsp_valid && (outst_reg != '0);
   end

   // Outstanding count, queue occupancy and drop count for the next cycle.
   always_comb begin
      outst_next = outst_reg;
      if (accept)  outst_next = outst_next + ONE_C;
      if (rsp_dec) outst_next = outst_next - ONE_C;

      count_next = count_reg;
      if (redirect) begin
         count_next = '0;
      end else begin
         if (push) count_next = count_next + ONE_C;
         if (pop)  count_next = count_next - ONE_C;
      end

      drop_next = drop_reg;
      if (redirect) begin
         // Every request still in flight after this edge belongs to the old path.
         drop_next = rsp_dec ? (outst_reg - ONE_C) : outst_reg;
      end else if ((state_reg == ST_FLUSH) && mem_rsp_valid && (drop_reg != '0)) begin
         drop_next = drop_reg - ONE_C;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      if (redirect) begin
         state_next = (drop_next != '0) ? ST_FLUSH : ST_RUN;
      end else if ((state_reg == ST_FLUSH) && (drop_next == '0)) begin
         state_next = ST_RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= ST_RUN;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem_addr_reg <= START_ADDR;
         inst_pc_reg  <= START_ADDR;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         outst_reg    <= '0;
         drop_reg     <= '0;
      end else begin
         outst_reg <= outst_next;
         count_reg <= count_next;
         drop_reg  <= drop_next;
         if (redirect) begin
            mem_addr_reg <= target_pc;
            inst_pc_reg  <= target_pc;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
         end else begin
            if (accept) mem_addr_reg <= mem_addr_reg + WSTEP;
            if (pop) begin
               inst_pc_reg <= inst_pc_reg + WSTEP;
               rd_ptr_reg  <= rd_ptr_reg + ONE_P;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + ONE_P;
         end
      end
   end

   // Queue storage has no reset; the pointers define which entries are valid.
   always_ff @(posedge clock) begin
      if (push && !reset) queue_mem[wr_ptr_reg] <= mem_rsp_data;
   end

`ifdef FETCH_PF_PERF_EN
   logic [31:0] perf_fetch_reg, perf_redirect_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetch_reg    <= '0;
         perf_redirect_reg <= '0;
      end else begin
         if (accept)   perf_fetch_reg    <= perf_fetch_reg + 32'd1;
         if (redirect) perf_redirect_reg <= perf_redirect_reg + 32'd1;
      end
   end

   assign perf_fetch_cnt    = perf_fetch_reg;
   assign perf_redirect_cnt = perf_redirect_reg;
`endif

endmodule

// File: tb/tb_fetch_pf.sv
// -----------------------------------------------------------------------------
// tb_fetch_pf : directed bench for fetch_pf.
//
// A small memory model answers each accepted request one cycle later with
// data = address + 32'h10000000, in order. It can be held off with mem_on.
// A table of per-cycle vectors covers streaming, stall backpressure,
// ready-low hold and enable_fetch low. Hand-written sequences then cover
// redirect/flush, reset mid-operation, a redirect that coincides with a
// response, and address wrap.
// -----------------------------------------------------------------------------
module tb_fetch_pf;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_fetch, stall, redirect;
   logic [31:0] redirect_pc;
   logic        mem_req_valid, mem_req_ready, rw;
   logic [31:0] mem_addr, access_size;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_pc, inst_data;
`ifdef FETCH_PF_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
`endif

   fetch_pf dut (
      .clock         (clock),
      .reset         (reset),
      .enable_fetch  (enable_fetch),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .rw            (rw),
      .access_size   (access_size),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .inst_valid    (inst_valid),
      .inst_pc       (inst_pc),
      .inst_data     (inst_data)
`ifdef FETCH_PF_PERF_EN
      ,
      .perf_fetch_cnt    (perf_fetch_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit mem_on;
   logic [31:0] pend[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and run the memory model. Called shortly after an edge,
   // once the inputs for the current cycle are set; it returns 1 time unit after
   // the next rising edge.
   task automatic cycle();
      logic        acc;
      logic [31:0] acc_addr;
      logic        rsp_fire;
      #1;
      acc      = mem_req_valid && mem_req_ready;
      acc_addr = mem_addr;
      rsp_fire = mem_rsp_valid;
      @(posedge clock);
      #1;
      if (reset) begin
         pend.delete();
      end else begin
         if (rsp_fire) void'(pend.pop_front());
         if (acc) pend.push_back(acc_addr);
      end
      if (mem_on && !reset && pend.size() > 0) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = pend[0] + 32'h10000000;
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
   endtask

   typedef struct {
      logic        en;
      logic        st;
      logic        rdy;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_ipc;
   } vec_t;

   vec_t vecs[18];

   initial begin
      //            en    st    rdy   req   addr           iv    inst_pc
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h80020000, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h80020004, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h80020008, 1'b1, 32'h80020000};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8002000C, 1'b1, 32'h80020004};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h80020010, 1'b1, 32'h80020008};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h80020014, 1'b1, 32'h80020008};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80020018, 1'b1, 32'h80020008};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80020018, 1'b1, 32'h80020008};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h80020018, 1'b1, 32'h80020008};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h80020018, 1'b1, 32'h8002000C};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8002001C, 1'b1, 32'h80020010};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8002001C, 1'b1, 32'h80020014};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8002001C, 1'b1, 32'h80020018};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8002001C, 1'b0, 32'h0};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8002001C, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80020020, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80020020, 1'b1, 32'h8002001C};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80020020, 1'b0, 32'h0};

      reset = 1'b1; enable_fetch = 1'b1; stall = 1'b0; redirect = 1'b0;
      redirect_pc = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      mem_rsp_data = '0; mem_on = 1'b1;
      #1;
      cycle();
      cycle();

      // Reset state, sampled while reset is still held.
      chk("rst_mem_addr",  mem_addr, 32'h80020000);
      chk("rst_inst_pc",   inst_pc, 32'h80020000);
      chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_rw",        {31'b0, rw}, 32'd1);
      chk("rst_access",    access_size, 32'd4);
      reset = 1'b0;

      // Streaming, stall backpressure, ready low, enable low.
      for (int i = 0; i < 18; i++) begin
         enable_fetch  = vecs[i].en;
         stall         = vecs[i].st;
         mem_req_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vecs[i].exp_req});
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_iv});
         if (vecs[i].exp_iv) begin
            chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_ipc);
            chk($sformatf("v%0d_inst_data", i), inst_data, vecs[i].exp_ipc + 32'h10000000);
         end
         $display("vec %0d: req=%b addr=%h inst_valid=%b inst_pc=%h inst_data=%h",
                  i, mem_req_valid, mem_addr, inst_valid, inst_pc, inst_data);
         cycle();
      end

      // Redirect with two requests in flight: both responses are flushed.
      mem_on = 1'b0; enable_fetch = 1'b1; mem_req_ready = 1'b1; stall = 1'b0;
      #1;
      chk("flush_pre_req", {31'b0, mem_req_valid}, 32'd1);
      cycle();
      cycle();
      redirect = 1'b1; redirect_pc = 32'h80030002; mem_on = 1'b1;
      #1;
      chk("flush_redir_noreq", {31'b0, mem_req_valid}, 32'd0);
      cycle();
      redirect = 1'b0;
      #1;
      chk("flush_q_empty",  {31'b0, inst_valid}, 32'd0);
      chk("flush_noreq1",   {31'b0, mem_req_valid}, 32'd0);
      chk("flush_addr",     mem_addr, 32'h80030000);
      chk("flush_inst_pc",  inst_pc, 32'h80030000);
      cycle();
      chk("flush_noreq2",   {31'b0, mem_req_valid}, 32'd0);
      chk("flush_q_empty2", {31'b0, inst_valid}, 32'd0);
      cycle();
      chk("flush_resume",   {31'b0, mem_req_valid}, 32'd1);
      chk("flush_res_addr", mem_addr, 32'h80030000);
      cycle();
      chk("flush_next_addr", mem_addr, 32'h80030004);
      cycle();
      chk("flush_first_iv",  {31'b0, inst_valid}, 32'd1);
      chk("flush_first_pc",  inst_pc, 32'h80030000);
      chk("flush_first_dat", inst_data, 32'h90030000);
      $display("seq redirect-flush: inst_pc=%h inst_data=%h", inst_pc, inst_data);

      // Reset in the middle of streaming.
      reset = 1'b1;
      cycle();
      chk("mid_rst_addr", mem_addr, 32'h80020000);
      chk("mid_rst_pc",   inst_pc, 32'h80020000);
      chk("mid_rst_iv",   {31'b0, inst_valid}, 32'd0);
      chk("mid_rst_req",  {31'b0, mem_req_valid}, 32'd0);
      reset = 1'b0;
      #1;
      chk("mid_rst_req_after", {31'b0, mem_req_valid}, 32'd1);
      $display("seq reset-mid-op: mem_addr=%h", mem_addr);

      // Redirect coinciding with the response to the only outstanding request.
      cycle();
      chk("coinc_rsp_present", {31'b0, mem_rsp_valid}, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h80040000;
      #1;
      chk("coinc_noreq", {31'b0, mem_req_valid}, 32'd0);
      cycle();
      redirect = 1'b0;
      #1;
      chk("coinc_dropped", {31'b0, inst_valid}, 32'd0);
      chk("coinc_run_req", {31'b0, mem_req_valid}, 32'd1);
      chk("coinc_addr",    mem_addr, 32'h80040000);
      cycle();
      chk("coinc_next_addr", mem_addr, 32'h80040004);
      $display("seq redirect-with-response: mem_addr=%h", mem_addr);

      // Address wrap at the top of the address space.
      reset = 1'b1;
      cycle();
      reset = 1'b0; enable_fetch = 1'b0;
      redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      cycle();
      redirect = 1'b0; enable_fetch = 1'b1;
      #1;
      chk("wrap_req",  {31'b0, mem_req_valid}, 32'd1);
      chk("wrap_addr", mem_addr, 32'hFFFFFFFC);
      cycle();
      chk("wrap_next_addr", mem_addr, 32'h00000000);
      cycle();
      enable_fetch = 1'b0;
      #1;
      chk("wrap_iv",   {31'b0, inst_valid}, 32'd1);
      chk("wrap_pc",   inst_pc, 32'hFFFFFFFC);
      chk("wrap_data", inst_data, 32'h0FFFFFFC);
      cycle();
      chk("wrap_pc2",   inst_pc, 32'h00000000);
      chk("wrap_data2", inst_data, 32'h10000000);
`ifdef FETCH_PF_PERF_EN
      chk("perf_fetch",    perf_fetch_cnt, 32'd2);
      chk("perf_redirect", perf_redirect_cnt, 32'd1);
`endif
      $display("seq wrap: inst_pc=%h mem_addr=%h", inst_pc, mem_addr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
